aes_block_assembler: RTL and testbench
======================================

// Module: aes_block_assembler
// PURPOSE
//  Collects the ciphertext byte stream from the serial receive path into 128-bit AES blocks.
//  Each completed block is presented on a valid/ready output to the AES-128 decrypt stage.
//  The decrypt stage is combinational; its consumer registers the 32-bit template word.
//  Buffering is two-deep: one assembly register plus one output register.
//  A block can therefore be filling while the previous one waits for acceptance.
// PARAMETERS
//  TIMEOUT_CYCLES  2000000  idle cycles allowed between bytes of a partial block before it is discarded
//  MSB_FIRST       1        1: first byte lands in out_block[127:120]; 0: first byte lands in out_block[7:0]
// PORTS
//  clk          in   1    system clock; all logic is on the rising edge
//  rst_n        in   1    synchronous reset, active-low
//  in_valid     in   1    in_data is valid this cycle; there is no backpressure on this side
//  in_data      in   8    ciphertext byte
//  out_block    out  128  assembled ciphertext block, connected to the decrypt stage encrypted_message input
//  out_valid    out  1    out_block holds an unconsumed block
//  out_ready    in   1    consumer accepts the block when out_valid && out_ready
//  busy         out  1    1 while the assembler holds a partial or full block (state != IDLE)
//  overrun_err  out  1    1-cycle pulse: byte dropped because both buffers were full
//  timeout_err  out  1    1-cycle pulse: partial block discarded on inter-byte timeout
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; byte count=0; timeout counter=0.
//   - out_valid=0, out_block=0, busy=0, overrun_err=0, timeout_err=0.
//   - Any partial or held block is discarded, including one arriving mid-fill.
//  States:
//   - IDLE: count=0.
//   - FILL: 1..15 bytes held.
//   - FULL: 16 bytes held, output register occupied.
//  Byte placement (MSB_FIRST=1):
//   - byte k (k=0..15) goes to asm[127-8k -: 8].
//   - MSB_FIRST=0 mirrors this: byte k goes to asm[8k +: 8].
//  "Output free" means out_valid==0 OR (out_valid && out_ready) in the same cycle.
//  Transitions:
//   - IDLE --byte--> FILL with count=1.
//   - FILL --byte, count<15--> FILL, count+1.
//   - FILL --16th byte, output free--> block is written straight to out_block; out_valid=1 on the next cycle (latency 1); go to IDLE.
//   - FILL --16th byte, output not free--> go to FULL.
//   - FULL --output frees--> asm moves to out_block at that edge, so out_valid stays high with no bubble; go to IDLE.
//     If a byte arrives on that same cycle, it is accepted as byte 0 of the next block and the state goes to FILL with count=1.
//   - FULL, byte arrives, output not free--> byte dropped; overrun_err pulses next cycle; state and data are unchanged.
//  Output handshake:
//   - out_block is stable while out_valid=1 && out_ready=0.
//   - out_valid drops the cycle after acceptance unless a new block is loaded on the same edge.
//  busy=1 in FILL or FULL.
//  The two error pulses never assert together.
// CONFIGURATION
//  AES_ASM_TIMEOUT_EN defined:
//   - Timeout counter runs only in FILL. It clears on every accepted byte and increments each idle cycle.
//   - Counter reaching TIMEOUT_CYCLES-1 with no byte: discard asm, go to IDLE, pulse timeout_err next cycle.
//   - A byte arriving in the expiry cycle wins: it is accepted and the counter clears.
//   - out_valid and out_block are never affected by a timeout.
//  AES_ASM_TIMEOUT_EN undefined:
//   - No counter logic.
//   - timeout_err is tied to 0.
//   - A partial block is held indefinitely until more bytes arrive or reset.
// TESTING
//  Bench setup: TIMEOUT_CYCLES=50, MSB_FIRST=1, macro defined unless noted.
//  1. Bytes 0x00..0x0F on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after byte 0x0F;
//     out_block=128'h000102030405060708090A0B0C0D0E0F; busy=0 afterwards.
//  2. out_ready=0, send 32 bytes 0x00..0x1F -> block 1 is held and state is FULL; send a 33rd byte 0xAA ->
//     overrun_err pulses once; raise out_ready -> 128'h00..0F then 128'h10..1F with no out_valid gap.
//  3. Send 5 bytes, then stay idle 50 cycles -> timeout_err 1-cycle pulse, busy=0;
//     then 16 bytes 0xF0..0xFF -> out_block=128'hF0F1...FF with no stale bytes.
//  4. Send 8 bytes, assert rst_n=0 for 1 cycle, then 16 bytes 0x20..0x2F -> exactly one block,
//     128'h202122...2F; all outputs read 0 during reset.
//  5. FULL state, apply out_ready=1 together with in_valid=1 and in_data=0x55 -> held block is moved out;
//     0x55 becomes byte 0 of the next block; count=1; no overrun.
//  6. Macro undefined: 5 bytes, idle 1000 cycles, 11 more bytes 0x05..0x0F -> one block 128'h00..0F; timeout_err never asserts.

Source files
------------

// File: rtl/aes_block_assembler.sv
// Packs a ciphertext byte stream into 128-bit AES blocks behind a 2-deep buffer.
// Optional inter-byte timeout is enabled with `define AES_ASM_TIMEOUT_EN.
module aes_block_assembler #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic [127:0] out_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun_err,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t        state;
    logic [127:0]  asm_q;
    logic [127:0]  asm_next;
    logic [3:0]    count;
    logic          out_free;

`ifdef AES_ASM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`endif

    function automatic logic [127:0] place(
        input logic [127:0] base,
        input logic [3:0]   k,
        input logic [7:0]   b
    );
        logic [127:0] r;
        logic [3:0]   slot;
        r    = base;
        slot = MSB_FIRST ? (4'd15 - k) : k;
        r[{slot, 3'b000} +: 8] = b;
        return r;
    endfunction

    // A new block starts from zero so no stale bytes survive a discard.
    assign asm_next = place((state == FILL) ? asm_q : '0, count, in_data);
    assign out_free = !out_valid || out_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            asm_q       <= '0;
            count       <= '0;
            out_block   <= '0;
            out_valid   <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
`ifdef AES_ASM_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        asm_q <= asm_next;
                        count <= 4'd1;
                        state <= FILL;
`ifdef AES_ASM_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        asm_q <= asm_next;
`ifdef AES_ASM_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                        if (count == 4'd15) begin
                            count <= '0;
                            if (out_free) begin
                                out_block <= asm_next;
                                out_valid <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state <= FULL;
                            end
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
`ifdef AES_ASM_TIMEOUT_EN
                    else if (tcnt == TMAX) begin
                        state       <= IDLE;
                        count       <= '0;
                        tcnt        <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                FULL: begin
                    if (out_free) begin
                        out_block <= asm_q;
                        out_valid <= 1'b1;
                        if (in_valid) begin
                            asm_q <= asm_next;
                            count <= 4'd1;
                            state <= FILL;
`ifdef AES_ASM_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else if (in_valid) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_assembler.sv
// Scoreboard bench for aes_block_assembler with directed byte streams.
// Runs the timeout scenario when AES_ASM_TIMEOUT_EN is defined, else the hold scenario.
module tb_aes_block_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic [127:0] out_block;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun_err;
    logic         timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ovr_cnt   = 0;
    int tmo_cnt   = 0;
    int both_cnt  = 0;
    logic [127:0] exp_q[$];
    logic         prev_hold = 1'b0;
    logic [127:0] prev_blk  = '0;

    always #5 clk = ~clk;

    aes_block_assembler #(
        .TIMEOUT_CYCLES(50),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_block(out_block),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(int'(base) + i));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted block.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun_err) ovr_cnt++;
            if (timeout_err) tmo_cnt++;
            if (overrun_err && timeout_err) both_cnt++;
            if (prev_hold && out_valid)
                check("hold_stable", out_block, prev_blk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_block: got %h expected none", out_block);
                end else begin
                    check("block", out_block, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_blk  = out_block;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cycles(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_block", out_block, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        cycles(1);

        // 1: straight-through block
        out_ready = 1'b1;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        send_seq(8'h00, 16);
        check("t1_valid", out_valid, 1);
        check("t1_busy", busy, 0);
        cycles(1);
        check("t1_valid_drop", out_valid, 0);

        // 2: two blocks buffered, overrun, back-to-back drain
        out_ready = 1'b0;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
        send_seq(8'h00, 32);
        check("t2_full_busy", busy, 1);
        check("t2_full_valid", out_valid, 1);
        check("t2_held_block", out_block, 128'h000102030405060708090A0B0C0D0E0F);
        send_byte(8'hAA);
        check("t2_overrun", overrun_err, 1);
        cycles(1);
        check("t2_overrun_end", overrun_err, 0);
        out_ready = 1'b1;
        cycles(1);
        check("t2_no_gap", out_valid, 1);
        check("t2_second", out_block, 128'h101112131415161718191A1B1C1D1E1F);
        check("t2_idle", busy, 0);
        cycles(1);
        check("t2_drained", out_valid, 0);

`ifdef AES_ASM_TIMEOUT_EN
        // 3: inter-byte timeout discards partial block
        send_seq(8'h00, 5);
        cycles(49);
        check("t3_pre_tmo", timeout_err, 0);
        check("t3_pre_busy", busy, 1);
        cycles(1);
        check("t3_timeout", timeout_err, 1);
        check("t3_busy", busy, 0);
        cycles(1);
        check("t3_tmo_end", timeout_err, 0);
        exp_q.push_back(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        send_seq(8'hF0, 16);
        cycles(2);
`else
        // 6: partial block held without timeout
        send_seq(8'h00, 5);
        cycles(1000);
        check("t6_busy", busy, 1);
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        send_seq(8'h05, 11);
        cycles(2);
`endif

        // 4: reset mid-fill
        send_seq(8'h77, 8);
        rst_n = 1'b0;
        cycles(1);
        check("t4_out_valid", out_valid, 0);
        check("t4_out_block", out_block, 0);
        check("t4_busy", busy, 0);
        check("t4_errs", {overrun_err, timeout_err}, 0);
        rst_n = 1'b1;
        exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
        send_seq(8'h20, 16);
        cycles(2);

        // 5: drain from FULL while a new byte arrives
        out_ready = 1'b0;
        exp_q.push_back(128'h303132333435363738393A3B3C3D3E3F);
        exp_q.push_back(128'h404142434445464748494A4B4C4D4E4F);
        exp_q.push_back(128'h55565758595A5B5C5D5E5F6061626364);
        send_seq(8'h30, 32);
        out_ready = 1'b1;
        send_byte(8'h55);
        check("t5_busy", busy, 1);
        check("t5_valid", out_valid, 1);
        check("t5_moved", out_block, 128'h404142434445464748494A4B4C4D4E4F);
        check("t5_no_overrun", overrun_err, 0);
        send_seq(8'h56, 15);
        cycles(3);

        check("queue_drained", 128'(exp_q.size()), 0);
        check("overrun_count", 128'(ovr_cnt), 1);
`ifdef AES_ASM_TIMEOUT_EN
        check("timeout_count", 128'(tmo_cnt), 1);
`else
        check("timeout_count", 128'(tmo_cnt), 0);
`endif
        check("err_exclusive", 128'(both_cnt), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
